// File: rtl/i2c_reg_target_if.sv
// Bus pins and register-port bundle shared by the I2C target and
// whatever drives the bus / hosts the register bank.
interface i2c_reg_target_if #(
  parameter int PTR_W = 8
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_wr;
  logic             reg_rd;
  logic [7:0]       reg_rdata;

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata,
    input  reg_wr, reg_rd
  );

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata,
    output reg_wr, reg_rd
  );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit addressed responder mapping bus bytes
// onto a single-cycle register port (pointer, write, read).
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         PTR_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  i2c_reg_target_if.slave bus,
  output logic            busy,
  output logic            addr_hit
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR_BYTE,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t           state, state_n;
  logic [1:0]       scl_q, sda_q;
  logic             scl_d, sda_d;
  logic [3:0]       cnt, cnt_n;
  logic [7:0]       sh, sh_n;
  logic             rw, rw_n;
  logic             oe, oe_n;
  logic [PTR_W-1:0] addr, addr_n;
  logic [7:0]       wdata, wdata_n;
  logic             wr, wr_n;
  logic             rd, rd_n;
  logic             busy_n, hit_n;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start, stop;
  logic [7:0] rx;

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
  assign rx       = {sh[6:0], sda_s};

  assign bus.sda_oe    = oe;
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata;
  assign bus.reg_wr    = wr;
  assign bus.reg_rd    = rd;

  // Synchronisers reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q    <= 2'b11;
      sda_q    <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      rw       <= 1'b0;
      oe       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
    end else begin
      scl_q    <= {scl_q[0], bus.scl_in};
      sda_q    <= {sda_q[0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      rw       <= rw_n;
      oe       <= oe_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      wr       <= wr_n;
      rd       <= rd_n;
      busy     <= busy_n;
      addr_hit <= hit_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = rd ? bus.reg_rdata : sh;
    rw_n    = rw;
    oe_n    = oe;
    addr_n  = wr ? addr + PTR_W'(1) : addr;
    wdata_n = wdata;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    busy_n  = busy;
    hit_n   = addr_hit;

    if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      busy_n  = 1'b1;
      hit_n   = 1'b0;
      oe_n    = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      hit_n   = 1'b0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = rx;
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            rw_n  = sh[0];
            if (sh[7:1] == TARGET_ADDR) begin
              state_n = ADDR_ACK;
              oe_n    = 1'b1;
              hit_n   = 1'b1;
              rd_n    = sh[0];
            end else begin
              state_n = WAIT_STOP;
              oe_n    = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_n = RD_BYTE;
              oe_n    = ~sh[7];
              sh_n    = {sh[6:0], 1'b0};
              cnt_n   = 4'd1;
            end else begin
              state_n = PTR_BYTE;
              oe_n    = 1'b0;
              cnt_n   = '0;
            end
          end
        end
        PTR_BYTE, WR_BYTE: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = rx;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == PTR_BYTE) begin
                addr_n = PTR_W'(rx);
              end else begin
                wdata_n = rx;
                wr_n    = 1'b1;
              end
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = WR_ACK;
            oe_n    = 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n = WR_BYTE;
            oe_n    = 1'b0;
            cnt_n   = '0;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RD_ACK;
              oe_n    = 1'b0;
              cnt_n   = '0;
            end else begin
              oe_n  = ~sh[7];
              sh_n  = {sh[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
        end
        // First bit of the next byte goes out on the falling edge
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_n = RD_BYTE;
              addr_n  = addr + PTR_W'(1);
              rd_n    = 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: oe_n = 1'b0;
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

endmodule
